cache_line_ctrl: RTL and testbench
==================================

# cache_line_ctrl

Parametrised control FSM for the direct-mapped, write-back, write-allocate data cache. It sits between the CPU memory-stage request and the cache array and banked main memory, and it sequences compare, write-back, line fill and write-miss merge. This block replaces the fixed 4-word, fixed-latency controller with three changes:

- a configurable line length;
- a stall-aware memory handshake (`mem_stall` / `mem_rd_vld`) instead of hard-coded memory timing;
- optional hit/miss statistics.

## Interface
- `WORDS`, default 4: words per line; power of two, ≥2.
- `OFF_W`, default `$clog2(WORDS)`: word-offset width; derived, never overridden.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req_rd`  in  1  CPU read request; sampled in IDLE only.
- `req_wr`  in  1  CPU write request; sampled in IDLE only; wins if both asserted.
- `hit`  in  1  tag match from cache array (valid in COMPARE).
- `valid`  in  1  line valid bit from cache array.
- `dirty`  in  1  line dirty bit from cache array.
- `mem_stall`  in  1  memory cannot accept the request presented this cycle.
- `mem_rd_vld`  in  1  memory read data returned this cycle, in issue order.
- `ready`  out  1  controller idle, can accept a request.
- `done`  out  1  one-cycle pulse: request completed.
- `hit_out`  out  1  1 if request hit on first compare; held until next request accepted.
- `cache_en`  out  1  cache array access enable.
- `cache_comp`  out  1  compare-mode access.
- `cache_write`  out  1  cache array write.
- `cache_valid_in`  out  1  valid bit written with `cache_write`.
- `sel_fill`  out  1  cache write data from memory (1) or CPU (0).
- `sel_wb_tag`  out  1  memory address uses stored tag (write-back).
- `cache_off`  out  `OFF_W`  cache word offset.
- `mem_rd`  out  1  memory read request.
- `mem_wr`  out  1  memory write request.
- `mem_off`  out  `OFF_W`  memory word offset.
- `hit_cnt`, `miss_cnt`  out  16 each  statistics; only with `CACHE_CTRL_STATS_EN`.

## Operation
- **States:** IDLE, COMPARE, WB, FILL, WMISS.
- **IDLE**
  - `ready`=1.
  - On `req_rd|req_wr`: latch `is_wr`=`req_wr`, set `first`=1, go to COMPARE.
- **COMPARE**
  - Drives `cache_en`=1 and `cache_comp`=1.
  - `cache_write`=`cache_valid_in`=`is_wr`, `sel_fill`=0.
  - If `hit&valid`: `done`=1 and `hit_out`=`first`, then go to IDLE.
  - Else if `valid&dirty`: go to WB.
  - Else: go to FILL.
  - Clear `first`.
- **WB**
  - Drives `cache_en`=1, `sel_wb_tag`=1, `mem_wr`=1.
  - `cache_off`=`mem_off`=`iss_cnt`.
  - `iss_cnt` increments only when `!mem_stall`.
  - When word `WORDS-1` is accepted: clear `iss_cnt`, go to FILL.
- **FILL** (issue and return overlap)
  - `mem_rd`=1 while `iss_cnt`<`WORDS`, with `mem_off`=`iss_cnt`; `iss_cnt` increments when `!mem_stall`.
  - On each `mem_rd_vld`: `cache_en`=`cache_write`=`cache_valid_in`=`sel_fill`=1, `cache_off`=`ret_cnt`, and `ret_cnt` increments.
  - When `ret_cnt` reaches `WORDS` (on a `mem_rd_vld`): go to WMISS if `is_wr`, else to COMPARE.
- **WMISS**
  - Drives `cache_en`=`cache_comp`=`cache_write`=`cache_valid_in`=1 (CPU word merged, dirty set).
  - Next state: COMPARE.
- **Counter widths:** `iss_cnt`/`ret_cnt` are `OFF_W+1` bits and are cleared on entry to WB/FILL.
- **Idle outputs:** `mem_rd_vld` outside FILL, or beyond `WORDS` returns, is ignored. Request inputs outside IDLE are ignored.

## Timing
- **Reset values:** state=IDLE; `ready`=1; all other outputs, counters, `is_wr` and `first` are 0.
- **Reset mid-operation:** an asserted `rst` aborts immediately. No further memory requests are driven; the memory side is responsible for discarding in-flight reads.
- **Hit latency:** accept in IDLE at cycle 0, COMPARE at cycle 1, `done` in cycle 1; IDLE with `ready`=1 at cycle 2.
- **Clean read miss, no stall, read latency L≥1:**
  - COMPARE at cycle 1.
  - Reads issued cycles 2..`WORDS`+1.
  - Returns cycles 2+L..`WORDS`+1+L.
  - COMPARE at `WORDS`+2+L, with `done` in that cycle.
- **Dirty miss:** adds `WORDS` cycles (WB) plus one cycle per stalled issue.
- **Stall rule:** `mem_rd`/`mem_wr` and `mem_off` hold stable while `mem_stall`=1.
- **Simultaneous events in FILL:** a return in the same cycle as an issue (or a stall) is legal; both counters update independently.

## Configuration
- `CACHE_CTRL_STATS_EN` defined: `hit_cnt`/`miss_cnt` ports exist.
  - `hit_cnt` increments on `done` with `first` set.
  - `miss_cnt` increments on first-compare miss.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Test plan
- `WORDS`=4, L=2, `req_rd` to a valid clean hit: `done`+`hit_out`=1 at cycle 1; `ready` at cycle 2.
- Clean read miss: `mem_rd` with `mem_off` 0,1,2,3 in cycles 2–5; 4 fill writes at `cache_off` 0–3; `done` at cycle 8 with `hit_out`=0.
- Dirty write miss with `mem_stall` high in cycle 3: WB offset 1 held for 2 cycles; FILL follows, then WMISS, then COMPARE `done`.
- `WORDS`=8, `req_rd` and `req_wr` asserted together: 8 WB/fill words; treated as a write (WMISS visited).
- `rst` low during FILL after 2 returns: state goes to IDLE in the same cycle with all outputs at reset values; a later `mem_rd_vld` is ignored.
- With `CACHE_CTRL_STATS_EN`, 3 hits then 1 miss: `hit_cnt`=3, `miss_cnt`=1.

Source files
------------

// File: rtl/cache_line_ctrl.sv
// cache_line_ctrl: control FSM for a direct-mapped, write-back, write-allocate
// data cache. It sequences compare, dirty-line write-back, line fill and the
// write-miss merge against a stall-aware, in-order memory interface.
//
// The line length is set by WORDS (a power of two, at least 2).
// Defining CACHE_CTRL_STATS_EN adds the hit_cnt/miss_cnt statistics ports.
//
// Outputs are decoded from registered state and counters. The decode also
// looks at the same-cycle hit/valid and mem_rd_vld inputs, because both the
// hit 'done' and the fill write have to happen in the cycle of the event.
module cache_line_ctrl #(
    parameter int WORDS = 4,
    localparam int OFF_W = $clog2(WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_rd,
    input  logic             req_wr,
    input  logic             hit,
    input  logic             valid,
    input  logic             dirty,
    input  logic             mem_stall,
    input  logic             mem_rd_vld,
    output logic             ready,
    output logic             done,
    output logic             hit_out,
    output logic             cache_en,
    output logic             cache_comp,
    output logic             cache_write,
    output logic             cache_valid_in,
    output logic             sel_fill,
    output logic             sel_wb_tag,
    output logic [OFF_W-1:0] cache_off,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic [OFF_W-1:0] mem_off
`ifdef CACHE_CTRL_STATS_EN
    ,
    output logic [15:0]      hit_cnt,
    output logic [15:0]      miss_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COMPARE,
        S_WB,
        S_FILL,
        S_WMISS
    } state_t;

    // Counters carry one extra bit so "all WORDS words issued" is representable.
    localparam logic [OFF_W:0] CNT_ONE  = (OFF_W+1)'(1);
    localparam logic [OFF_W:0] CNT_LAST = (OFF_W+1)'(WORDS - 1);
    localparam logic [OFF_W:0] CNT_FULL = (OFF_W+1)'(WORDS);

    state_t         state_reg;
    logic           is_wr_reg;
    logic           first_reg;
    logic           hit_out_reg;
    logic [OFF_W:0] iss_cnt_reg;
    logic [OFF_W:0] ret_cnt_reg;

`ifdef CACHE_CTRL_STATS_EN
    logic [15:0]    hit_cnt_reg;
    logic [15:0]    miss_cnt_reg;
    assign hit_cnt  = hit_cnt_reg;
    assign miss_cnt = miss_cnt_reg;
`endif

    logic lookup_hit;
    logic iss_pending;
    logic ret_take;

    assign lookup_hit  = hit & valid;
    assign iss_pending = (iss_cnt_reg < CNT_FULL);
    // Returns beyond the last word of the line are dropped.
    assign ret_take    = (state_reg == S_FILL) && mem_rd_vld && (ret_cnt_reg < CNT_FULL);

    // A first-compare hit is reported in its own cycle and then held until
    // the next request is accepted.
    assign hit_out = hit_out_reg | ((state_reg == S_COMPARE) & lookup_hit & first_reg);

    // State, issue/return counters, request flags and statistics.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= S_IDLE;
            is_wr_reg    <= 1'b0;
            first_reg    <= 1'b0;
            hit_out_reg  <= 1'b0;
            iss_cnt_reg  <= '0;
            ret_cnt_reg  <= '0;
`ifdef CACHE_CTRL_STATS_EN
            hit_cnt_reg  <= '0;
            miss_cnt_reg <= '0;
`endif
        end else begin
            unique case (state_reg)
                S_IDLE: begin
                    if (req_rd || req_wr) begin
                        is_wr_reg   <= req_wr;
                        first_reg   <= 1'b1;
                        hit_out_reg <= 1'b0;
                        state_reg   <= S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    first_reg <= 1'b0;
                    if (lookup_hit) begin
                        hit_out_reg <= first_reg;
                        state_reg   <= S_IDLE;
                    end else if (valid && dirty) begin
                        iss_cnt_reg <= '0;
                        ret_cnt_reg <= '0;
                        state_reg   <= S_WB;
                    end else begin
                        iss_cnt_reg <= '0;
                        ret_cnt_reg <= '0;
                        state_reg   <= S_FILL;
                    end
                end
                S_WB: begin
                    // The offset only advances once memory accepts the word.
                    if (!mem_stall) begin
                        if (iss_cnt_reg == CNT_LAST) begin
                            iss_cnt_reg <= '0;
                            ret_cnt_reg <= '0;
                            state_reg   <= S_FILL;
                        end else begin
                            iss_cnt_reg <= iss_cnt_reg + CNT_ONE;
                        end
                    end
                end
                S_FILL: begin
                    // Issue and return progress independently; they may coincide.
                    if (iss_pending && !mem_stall) begin
                        iss_cnt_reg <= iss_cnt_reg + CNT_ONE;
                    end
                    if (ret_take) begin
                        ret_cnt_reg <= ret_cnt_reg + CNT_ONE;
                        if (ret_cnt_reg == CNT_LAST) begin
                            state_reg <= is_wr_reg ? S_WMISS : S_COMPARE;
                        end
                    end
                end
                S_WMISS: begin
                    state_reg <= S_COMPARE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase

`ifdef CACHE_CTRL_STATS_EN
            // Only the first compare of a request is classified as hit or miss.
            if (state_reg == S_COMPARE && first_reg) begin
                if (lookup_hit) begin
                    if (hit_cnt_reg != 16'hFFFF) begin
                        hit_cnt_reg <= hit_cnt_reg + 16'd1;
                    end
                end else begin
                    if (miss_cnt_reg != 16'hFFFF) begin
                        miss_cnt_reg <= miss_cnt_reg + 16'd1;
                    end
                end
            end
`endif
        end
    end

    // Output decode for the cache array and memory sides.
    always_comb begin
        ready          = 1'b0;
        done           = 1'b0;
        cache_en       = 1'b0;
        cache_comp     = 1'b0;
        cache_write    = 1'b0;
        cache_valid_in = 1'b0;
        sel_fill       = 1'b0;
        sel_wb_tag     = 1'b0;
        cache_off      = '0;
        mem_rd         = 1'b0;
        mem_wr         = 1'b0;
        mem_off        = '0;
        unique case (state_reg)
            S_IDLE: begin
                ready = 1'b1;
            end
            S_COMPARE: begin
                cache_en       = 1'b1;
                cache_comp     = 1'b1;
                cache_write    = is_wr_reg;
                cache_valid_in = is_wr_reg;
                done           = lookup_hit;
            end
            S_WB: begin
                cache_en   = 1'b1;
                sel_wb_tag = 1'b1;
                mem_wr     = 1'b1;
                cache_off  = iss_cnt_reg[OFF_W-1:0];
                mem_off    = iss_cnt_reg[OFF_W-1:0];
            end
            S_FILL: begin
                mem_rd  = iss_pending;
                mem_off = iss_cnt_reg[OFF_W-1:0];
                if (ret_take) begin
                    cache_en       = 1'b1;
                    cache_write    = 1'b1;
                    cache_valid_in = 1'b1;
                    sel_fill       = 1'b1;
                    cache_off      = ret_cnt_reg[OFF_W-1:0];
                end
            end
            S_WMISS: begin
                // CPU word merged into the freshly filled line; marks it dirty.
                cache_en       = 1'b1;
                cache_comp     = 1'b1;
                cache_write    = 1'b1;
                cache_valid_in = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_cache_line_ctrl.sv
// tb_cache_line_ctrl: drives a 4-word and an 8-word cache_line_ctrl (one at a
// time, selected by 'sel') and compares every cycle against a timeline that
// is computed arithmetically from the request, the cache lookup result, the
// memory latency and the per-cycle stall pattern.
module tb_cache_line_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic req_rd, req_wr, hit, valid, dirty, mem_stall, mem_rd_vld;
    logic sel;

    logic [1:0] ready_w, done_w, hit_out_w, cache_en_w, cache_comp_w, cache_write_w;
    logic [1:0] cache_valid_in_w, sel_fill_w, sel_wb_tag_w, mem_rd_w, mem_wr_w;
    logic [1:0] c_off4, m_off4;
    logic [2:0] c_off8, m_off8;
`ifdef CACHE_CTRL_STATS_EN
    logic [15:0] hc4, mc4, hc8, mc8;
`endif

    cache_line_ctrl #(.WORDS(4)) dut4 (
        .clk(clk), .rst(rst),
        .req_rd(req_rd & ~sel), .req_wr(req_wr & ~sel),
        .hit(hit), .valid(valid), .dirty(dirty),
        .mem_stall(mem_stall), .mem_rd_vld(mem_rd_vld & ~sel),
        .ready(ready_w[0]), .done(done_w[0]), .hit_out(hit_out_w[0]),
        .cache_en(cache_en_w[0]), .cache_comp(cache_comp_w[0]),
        .cache_write(cache_write_w[0]), .cache_valid_in(cache_valid_in_w[0]),
        .sel_fill(sel_fill_w[0]), .sel_wb_tag(sel_wb_tag_w[0]),
        .cache_off(c_off4), .mem_rd(mem_rd_w[0]), .mem_wr(mem_wr_w[0]),
        .mem_off(m_off4)
`ifdef CACHE_CTRL_STATS_EN
        , .hit_cnt(hc4), .miss_cnt(mc4)
`endif
    );

    cache_line_ctrl #(.WORDS(8)) dut8 (
        .clk(clk), .rst(rst),
        .req_rd(req_rd & sel), .req_wr(req_wr & sel),
        .hit(hit), .valid(valid), .dirty(dirty),
        .mem_stall(mem_stall), .mem_rd_vld(mem_rd_vld & sel),
        .ready(ready_w[1]), .done(done_w[1]), .hit_out(hit_out_w[1]),
        .cache_en(cache_en_w[1]), .cache_comp(cache_comp_w[1]),
        .cache_write(cache_write_w[1]), .cache_valid_in(cache_valid_in_w[1]),
        .sel_fill(sel_fill_w[1]), .sel_wb_tag(sel_wb_tag_w[1]),
        .cache_off(c_off8), .mem_rd(mem_rd_w[1]), .mem_wr(mem_wr_w[1]),
        .mem_off(m_off8)
`ifdef CACHE_CTRL_STATS_EN
        , .hit_cnt(hc8), .miss_cnt(mc8)
`endif
    );

    // Observed outputs of the selected instance.
    // Order: ready, done, en, comp, write, valid_in, sel_fill, sel_wb_tag, mem_rd, mem_wr
    logic [9:0] obs_vec;
    logic       obs_hit_out;
    logic [3:0] obs_moff, obs_coff;
    always_comb begin
        obs_vec = {ready_w[sel], done_w[sel], cache_en_w[sel], cache_comp_w[sel],
                   cache_write_w[sel], cache_valid_in_w[sel], sel_fill_w[sel],
                   sel_wb_tag_w[sel], mem_rd_w[sel], mem_wr_w[sel]};
        obs_hit_out = hit_out_w[sel];
        obs_moff = sel ? {1'b0, m_off8} : {2'b00, m_off4};
        obs_coff = sel ? {1'b0, c_off8} : {2'b00, c_off4};
    end

    localparam logic [9:0] READY_ONLY = 10'b10_0000_0000;

    int checks = 0;
    int errors = 0;
    int txn_no = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Transaction configuration.
    bit rq_rd, rq_wr, hit0, valid0, dirty0;
    int lat;
    bit stall_a[256];
    bit prev_hit[2];
    int hc_m[2];
    int mc_m[2];

    task automatic clear_stalls();
        for (int i = 0; i < 256; i++) stall_a[i] = 1'b0;
    endtask

    task automatic random_stalls();
        for (int i = 0; i < 256; i++) stall_a[i] = (i < 80) ? ($urandom_range(0, 3) == 0) : 1'b0;
    endtask

    // Runs one request starting in an IDLE cycle (called at posedge+1).
    // Cycles after stop_t are not driven, which leaves the DUT mid-operation.
    task automatic run_txn(input int stop_t);
        int w, t, fc, fs, fe, wm, wb_end, last_rd, nwb, nrd, ridx;
        int wb_cyc[8];
        int rd_cyc[8];
        int ret_cyc[8];
        bit first_hit, has_wb, is_w, ret, st_cmp, st_wb, st_fill, st_wm, e_rd;
        logic [9:0] ev;

        w = sel ? 8 : 4;
        first_hit = hit0 && valid0;
        is_w = rq_wr;
        has_wb = 1'b0;
        for (int k = 0; k < 8; k++) begin
            wb_cyc[k] = -1; rd_cyc[k] = -1; ret_cyc[k] = -1;
        end
        fs = -1; fe = -2; wm = -1; wb_end = -1; last_rd = -1;
        if (first_hit) begin
            fc = 1;
        end else begin
            t = 2;
            has_wb = valid0 && dirty0;
            if (has_wb) begin
                for (int k = 0; k < w; k++) begin
                    while (stall_a[t]) t++;
                    wb_cyc[k] = t;
                    t++;
                end
                wb_end = t - 1;
            end
            fs = t;
            for (int k = 0; k < w; k++) begin
                while (stall_a[t]) t++;
                rd_cyc[k] = t;
                ret_cyc[k] = t + lat;
                t++;
            end
            last_rd = rd_cyc[w-1];
            fe = ret_cyc[w-1];
            wm = is_w ? fe + 1 : -1;
            fc = is_w ? fe + 2 : fe + 1;
        end

        for (t = 0; t <= fc && t <= stop_t; t++) begin
            ret = 1'b0;
            ridx = 0;
            for (int k = 0; k < w; k++) begin
                if (ret_cyc[k] == t) begin
                    ret = 1'b1;
                    ridx = k;
                end
            end
            st_fill = (t >= fs) && (t <= fe);
            req_rd = (t == 0) ? rq_rd : 1'($urandom_range(0, 1));
            req_wr = (t == 0) ? rq_wr : 1'($urandom_range(0, 1));
            hit    = (t <= 1) ? hit0 : 1'b1;
            valid  = (t <= 1) ? valid0 : 1'b1;
            dirty  = (t <= 1) ? dirty0 : 1'($urandom_range(0, 1));
            mem_stall  = stall_a[t];
            mem_rd_vld = ret ? 1'b1 : (st_fill ? 1'b0 : 1'($urandom_range(0, 1)));
            #1;
            st_cmp = (t == 1) || (t == fc);
            st_wb  = has_wb && (t >= 2) && (t <= wb_end);
            st_wm  = (t == wm);
            e_rd   = st_fill && (t <= last_rd);
            nwb = 0;
            nrd = 0;
            for (int k = 0; k < w; k++) begin
                if (wb_cyc[k] >= 0 && wb_cyc[k] < t) nwb++;
                if (rd_cyc[k] >= 0 && rd_cyc[k] < t) nrd++;
            end
            ev = {t == 0, t == fc, st_cmp | st_wb | st_wm | ret, st_cmp | st_wm,
                  (st_cmp & is_w) | st_wm | ret, (st_cmp & is_w) | st_wm | ret,
                  ret, st_wb, e_rd, st_wb};
            check_eq("ctl", obs_vec, ev);
            check_eq("hit_out", obs_hit_out, (t == 0) ? prev_hit[sel] : first_hit);
            if (st_wb) begin
                check_eq("wb_mem_off", obs_moff, nwb);
                check_eq("wb_cache_off", obs_coff, nwb);
            end
            if (e_rd) check_eq("rd_mem_off", obs_moff, nrd);
            if (ret) check_eq("fill_off", obs_coff, ridx);
            @(posedge clk);
            #1;
        end

        if (stop_t >= fc) prev_hit[sel] = first_hit;
        if (stop_t >= 1) begin
            if (first_hit) hc_m[sel]++;
            else mc_m[sel]++;
        end
        txn_no++;
        $display("txn %0d W=%0d rd=%0b wr=%0b hit=%0b valid=%0b dirty=%0b L=%0d done_cycle=%0d",
                 txn_no, w, rq_rd, rq_wr, hit0, valid0, dirty0, lat, fc);
    endtask

    task automatic set_txn(input bit s, input bit r, input bit wr, input bit h,
                           input bit v, input bit d, input int l);
        sel = s; rq_rd = r; rq_wr = wr; hit0 = h; valid0 = v; dirty0 = d; lat = l;
    endtask

    task automatic check_stats(input string tag);
`ifdef CACHE_CTRL_STATS_EN
        check_eq({tag, "_hit4"}, hc4, hc_m[0]);
        check_eq({tag, "_miss4"}, mc4, mc_m[0]);
        check_eq({tag, "_hit8"}, hc8, hc_m[1]);
        check_eq({tag, "_miss8"}, mc8, mc_m[1]);
`endif
    endtask

    initial begin
        rst = 1'b0;
        sel = 1'b0;
        req_rd = 1'b0; req_wr = 1'b0; hit = 1'b0; valid = 1'b0; dirty = 1'b0;
        mem_stall = 1'b0; mem_rd_vld = 1'b0;
        prev_hit[0] = 1'b0; prev_hit[1] = 1'b0;
        hc_m[0] = 0; hc_m[1] = 0; mc_m[0] = 0; mc_m[1] = 0;
        clear_stalls();
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_ctl4", obs_vec, READY_ONLY);
        check_eq("reset_hit_out4", obs_hit_out, 1'b0);
        sel = 1'b1;
        #1;
        check_eq("reset_ctl8", obs_vec, READY_ONLY);
        sel = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Reset during FILL after two returns (issues at 2,3 -> returns at 4,5).
        set_txn(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2);
        run_txn(5);
        req_rd = 1'b0; req_wr = 1'b0; mem_stall = 1'b0; mem_rd_vld = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        check_eq("abort_ctl", obs_vec, READY_ONLY);
        check_eq("abort_hit_out", obs_hit_out, 1'b0);
        @(posedge clk);
        #1;
        check_eq("abort_hold_ctl", obs_vec, READY_ONLY);
        rst = 1'b1;
        mem_rd_vld = 1'b1;
        #1;
        check_eq("late_vld_ignored", obs_vec, READY_ONLY);
        @(posedge clk);
        #1;
        mem_rd_vld = 1'b0;
        check_eq("idle_after_abort", obs_vec, READY_ONLY);
        prev_hit[0] = 1'b0; prev_hit[1] = 1'b0;
        hc_m[0] = 0; hc_m[1] = 0; mc_m[0] = 0; mc_m[1] = 0;
        check_stats("after_reset");

        // Three hits, then a clean read miss with L=2.
        for (int i = 0; i < 3; i++) begin
            set_txn(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'($urandom_range(0, 1)), 2);
            run_txn(1000);
        end
        set_txn(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2);
        run_txn(1000);
        check_stats("hits3_miss1");

        // Dirty write miss with a stall in cycle 3 (WB offset 1 held).
        set_txn(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2);
        stall_a[3] = 1'b1;
        run_txn(1000);
        clear_stalls();

        // 8-word line, read and write together: treated as a write.
        set_txn(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3);
        run_txn(1000);

        // Randomized requests, lookups, latencies and stall patterns.
        for (int i = 0; i < 80; i++) begin
            set_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 1)), $urandom_range(1, 4));
            if (!rq_rd && !rq_wr) rq_rd = 1'b1;
            if ($urandom_range(0, 1) == 1) random_stalls();
            else clear_stalls();
            run_txn(1000);
        end
        clear_stalls();

        req_rd = 1'b0; req_wr = 1'b0; mem_rd_vld = 1'b0; mem_stall = 1'b0;
        sel = 1'b0;
        #1;
        check_eq("final_idle4", obs_vec, READY_ONLY);
        sel = 1'b1;
        #1;
        check_eq("final_idle8", obs_vec, READY_ONLY);
        check_stats("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
